id_ex_alu_decode: RTL

Instruction-decode-to-execute stage that produces the 6-bit ALU operation code consumed by the 32-bit MIPS ALU, together with ready-to-use A/B operands and the writeback and memory control for each instruction. It sits between the IF/ID register and the ALU. It combinationally decodes the IF/ID instruction word, then registers the result as the ID/EX pipeline register. The register supports stall, flush, and bubble insertion, and keeps a saturating count of illegal instructions.

---
 rtl/id_ex_alu_decode.sv | 243 ++++++++++++++++++++++++
 1 files changed

// File: rtl/id_ex_alu_decode.sv
// ID/EX stage: decodes the IF/ID instruction into an ALU op code, operands and control,
// then registers it with stall, flush and bubble handling plus an illegal-instruction counter.
module id_ex_alu_decode (
  input  logic        clk_i,
  input  logic        reset_i,
  input  logic [31:0] instruction_i,
  input  logic        in_valid_i,
  input  logic        stall_i,
  input  logic        flush_i,
  input  logic [31:0] rs_data_i,
  input  logic [31:0] rt_data_i,
  input  logic [31:0] pc_plus4_i,
  output logic [5:0]  alu_control_o,
  output logic [31:0] operand_a_o,
  output logic [31:0] operand_b_o,
  output logic [31:0] store_data_o,
  output logic [4:0]  write_reg_o,
  output logic        reg_write_o,
  output logic        mem_read_o,
  output logic        mem_write_o,
  output logic        is_branch_o,
  output logic        is_jump_o,
  output logic [1:0]  mem_size_o,
  output logic        out_valid_o,
  output logic        illegal_instr_o,
  output logic [7:0]  illegal_count_o
);

  localparam logic [5:0] AluAnd   = 6'd0;
  localparam logic [5:0] AluOr    = 6'd1;
  localparam logic [5:0] AluXor   = 6'd2;
  localparam logic [5:0] AluNor   = 6'd3;
  localparam logic [5:0] AluAdd   = 6'd4;
  localparam logic [5:0] AluSub   = 6'd5;
  localparam logic [5:0] AluMul   = 6'd6;
  localparam logic [5:0] AluSlt   = 6'd7;
  localparam logic [5:0] AluSll   = 6'd8;
  localparam logic [5:0] AluSrl   = 6'd9;
  localparam logic [5:0] AluBeq   = 6'd10;
  localparam logic [5:0] AluBne   = 6'd11;
  localparam logic [5:0] AluBgtz  = 6'd12;
  localparam logic [5:0] AluBgez  = 6'd13;
  localparam logic [5:0] AluBltz  = 6'd14;
  localparam logic [5:0] AluBlez  = 6'd15;
  localparam logic [5:0] AluPassA = 6'd16;
  localparam logic [5:0] AluPassB = 6'd17;

  localparam logic [1:0] SizeWord = 2'b00;
  localparam logic [1:0] SizeHalf = 2'b01;
  localparam logic [1:0] SizeByte = 2'b10;

  typedef struct packed {
    logic [5:0]  alu;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] sd;
    logic [4:0]  wr;
    logic        rw;
    logic        mr;
    logic        mw;
    logic        br;
    logic        j;
    logic [1:0]  ms;
    logic        ov;
    logic        ill;
  } idex_t;

  logic [5:0]  op, funct;
  logic [4:0]  rs, rt, rd, shamt;
  logic [15:0] imm;
  logic [31:0] imm_sext, imm_zext;

  assign op       = instruction_i[31:26];
  assign rs       = instruction_i[25:21];
  assign rt       = instruction_i[20:16];
  assign rd       = instruction_i[15:11];
  assign shamt    = instruction_i[10:6];
  assign funct    = instruction_i[5:0];
  assign imm      = instruction_i[15:0];
  assign imm_sext = {{16{imm[15]}}, imm};
  assign imm_zext = {16'b0, imm};

  idex_t dec;
  logic  illegal;

  always_comb begin
    dec     = '0;
    illegal = 1'b0;
    case (op)
      6'h00: begin
        dec.a  = rs_data_i;
        dec.b  = rt_data_i;
        dec.wr = rd;
        dec.rw = 1'b1;
        case (funct)
          6'h20: dec.alu = AluAdd;
          6'h22: dec.alu = AluSub;
          6'h24: dec.alu = AluAnd;
          6'h25: dec.alu = AluOr;
          6'h26: dec.alu = AluXor;
          6'h27: dec.alu = AluNor;
          6'h2A: dec.alu = AluSlt;
          6'h00: begin
            dec.alu = AluSll;
            dec.a   = {27'b0, shamt};
          end
          6'h02: begin
            dec.alu = AluSrl;
            dec.a   = {27'b0, shamt};
          end
          6'h08: begin
            dec.alu = AluPassA;
            dec.b   = '0;
            dec.wr  = '0;
            dec.rw  = 1'b0;
            dec.j   = 1'b1;
          end
          default: illegal = 1'b1;
        endcase
      end
      6'h1C: begin
        dec.alu = AluMul;
        dec.a   = rs_data_i;
        dec.b   = rt_data_i;
        dec.wr  = rd;
        dec.rw  = 1'b1;
        if (funct != 6'h02) illegal = 1'b1;
      end
      6'h08, 6'h0A, 6'h0C, 6'h0D, 6'h0E: begin
        dec.a  = rs_data_i;
        dec.wr = rt;
        dec.rw = 1'b1;
        case (op)
          6'h08:   begin dec.alu = AluAdd; dec.b = imm_sext; end
          6'h0A:   begin dec.alu = AluSlt; dec.b = imm_sext; end
          6'h0C:   begin dec.alu = AluAnd; dec.b = imm_zext; end
          6'h0D:   begin dec.alu = AluOr;  dec.b = imm_zext; end
          default: begin dec.alu = AluXor; dec.b = imm_zext; end
        endcase
      end
      6'h23, 6'h21, 6'h20: begin
        dec.alu = AluAdd;
        dec.a   = rs_data_i;
        dec.b   = imm_sext;
        dec.sd  = rt_data_i;
        dec.wr  = rt;
        dec.rw  = 1'b1;
        dec.mr  = 1'b1;
        dec.ms  = (op == 6'h23) ? SizeWord : (op == 6'h21) ? SizeHalf : SizeByte;
      end
      6'h2B, 6'h29, 6'h28: begin
        dec.alu = AluAdd;
        dec.a   = rs_data_i;
        dec.b   = imm_sext;
        dec.sd  = rt_data_i;
        dec.mw  = 1'b1;
        dec.ms  = (op == 6'h2B) ? SizeWord : (op == 6'h29) ? SizeHalf : SizeByte;
      end
      6'h04, 6'h05: begin
        dec.alu = (op == 6'h04) ? AluBeq : AluBne;
        dec.a   = rs_data_i;
        dec.b   = rt_data_i;
        dec.br  = 1'b1;
      end
      6'h06, 6'h07: begin
        dec.alu = (op == 6'h06) ? AluBlez : AluBgtz;
        dec.a   = rs_data_i;
        dec.br  = 1'b1;
      end
      6'h01: begin
        dec.a  = rs_data_i;
        dec.br = 1'b1;
        case (rt)
          5'd0:    dec.alu = AluBltz;
          5'd1:    dec.alu = AluBgez;
          default: illegal = 1'b1;
        endcase
      end
      6'h02: dec.j = 1'b1;
      6'h03: begin
        dec.alu = AluPassB;
        dec.b   = pc_plus4_i;
        dec.wr  = 5'd31;
        dec.rw  = 1'b1;
        dec.j   = 1'b1;
      end
      default: illegal = 1'b1;
    endcase

    // Writes to $0 are architecturally dead, so drop the enable here.
    if (dec.wr == 5'd0) dec.rw = 1'b0;

    if (illegal) begin
      dec     = '0;
      dec.ill = 1'b1;
    end
    dec.ov = 1'b1;
  end

  idex_t      pipe_d, pipe_q;
  logic [7:0] cnt_d, cnt_q;

  always_comb begin
    pipe_d = pipe_q;
    cnt_d  = cnt_q;
    if (flush_i) begin
      pipe_d = '0;
    end else if (!stall_i) begin
      if (!in_valid_i) begin
        pipe_d = '0;
      end else begin
        pipe_d = dec;
        if (dec.ill && cnt_q != 8'hFF) cnt_d = cnt_q + 8'd1;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      pipe_q <= '0;
      cnt_q  <= '0;
    end else begin
      pipe_q <= pipe_d;
      cnt_q  <= cnt_d;
    end
  end

  assign alu_control_o   = pipe_q.alu;
  assign operand_a_o     = pipe_q.a;
  assign operand_b_o     = pipe_q.b;
  assign store_data_o    = pipe_q.sd;
  assign write_reg_o     = pipe_q.wr;
  assign reg_write_o     = pipe_q.rw;
  assign mem_read_o      = pipe_q.mr;
  assign mem_write_o     = pipe_q.mw;
  assign is_branch_o     = pipe_q.br;
  assign is_jump_o       = pipe_q.j;
  assign mem_size_o      = pipe_q.ms;
  assign out_valid_o     = pipe_q.ov;
  assign illegal_instr_o = pipe_q.ill;
  assign illegal_count_o = cnt_q;

endmodule
